// File: rtl/memory_loader_pkg.sv
// memory_loader_pkg: shared debugger loader constants, defaults and state encoding
package memory_loader_pkg;
  localparam int DEFAULT_MEMORY_LOADER_UART_BUS_SIZE = 8;
  localparam int DEFAULT_MEMORY_LOADER_WORD_SIZE = 32;
  localparam int DEFAULT_MEMORY_LOADER_ADDR_SIZE = 8;
  localparam logic [31:0] DEFAULT_MEMORY_LOADER_HALT_WORD = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {
    MEMORY_LOADER_STATE_IDLE    = 2'd0,
    MEMORY_LOADER_STATE_RECEIVE = 2'd1,
    MEMORY_LOADER_STATE_WRITE   = 2'd2,
    MEMORY_LOADER_STATE_DONE    = 2'd3
  } state_t;
endpackage

// File: rtl/memory_loader_if.sv
// memory_loader_if: start/UART byte inputs and memory write/status outputs of the loader
interface memory_loader_if #(
  parameter int UART_BUS_SIZE = 8,
  parameter int WORD_SIZE = 32,
  parameter int ADDR_SIZE = 8
);
  logic                     i_start;
  logic                     i_rx_done;
  logic [UART_BUS_SIZE-1:0] i_rx_data;
  logic                     o_wr_en;
  logic [ADDR_SIZE-1:0]     o_wr_addr;
  logic [WORD_SIZE-1:0]     o_wr_data;
  logic                     o_busy;
  logic                     o_end;
  logic                     o_error;
  logic [ADDR_SIZE:0]       o_word_count;
  modport slave (
    input  i_start, i_rx_done, i_rx_data,
    output o_wr_en, o_wr_addr, o_wr_data, o_busy, o_end, o_error, o_word_count
  );
  modport master (
    output i_start, i_rx_done, i_rx_data,
    input  o_wr_en, o_wr_addr, o_wr_data, o_busy, o_end, o_error, o_word_count
  );
endinterface

// File: rtl/memory_loader.sv
// memory_loader: packs big-endian UART bytes into words and writes them sequentially until halt word or full memory
module memory_loader
  import memory_loader_pkg::*;
#(
  parameter int UART_BUS_SIZE = DEFAULT_MEMORY_LOADER_UART_BUS_SIZE,
  parameter int WORD_SIZE = DEFAULT_MEMORY_LOADER_WORD_SIZE,
  parameter int ADDR_SIZE = DEFAULT_MEMORY_LOADER_ADDR_SIZE,
  parameter logic [WORD_SIZE-1:0] HALT_WORD = WORD_SIZE'(DEFAULT_MEMORY_LOADER_HALT_WORD)
) (
  input logic i_clk,
  input logic i_reset,
  memory_loader_if.slave bus
);
  localparam int BYTES = WORD_SIZE / UART_BUS_SIZE;
  localparam int CW = BYTES > 1 ? $clog2(BYTES) : 1;
  state_t r_state, w_next_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [ADDR_SIZE-1:0] r_addr, w_addr, r_wr_addr;
  logic [WORD_SIZE-1:0] r_shift, w_shift, r_wr_data, w_wr_data;
  logic [ADDR_SIZE:0] r_words, w_words, r_word_count;
  logic r_err, w_err, r_wr_en, r_busy, r_end, r_error;
  logic w_start, w_take, w_last, w_write, w_halt, w_full;
  assign w_start = bus.i_start && (r_state == MEMORY_LOADER_STATE_IDLE || r_state == MEMORY_LOADER_STATE_DONE);
  assign w_take = bus.i_rx_done && r_state == MEMORY_LOADER_STATE_RECEIVE;
  assign w_last = r_cnt == CW'(BYTES - 1);
  assign w_write = r_state == MEMORY_LOADER_STATE_WRITE;
  assign w_halt = r_shift == HALT_WORD;
  assign w_full = &r_addr;
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= MEMORY_LOADER_STATE_IDLE;
      r_cnt <= '0;
      r_addr <= '0;
      r_shift <= '0;
      r_words <= '0;
      r_err <= 1'b0;
      r_wr_en <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_busy <= 1'b0;
      r_end <= 1'b0;
      r_error <= 1'b0;
      r_word_count <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt <= w_cnt;
      r_addr <= w_addr;
      r_shift <= w_shift;
      r_words <= w_words;
      r_err <= w_err;
      r_wr_en <= w_write;
      r_wr_addr <= r_addr;
      r_wr_data <= w_wr_data;
      r_busy <= r_state == MEMORY_LOADER_STATE_RECEIVE || w_write;
      r_end <= r_state == MEMORY_LOADER_STATE_DONE;
      r_error <= r_err;
      r_word_count <= r_words;
    end
  end
  always_comb begin
    w_next_state = w_start ? MEMORY_LOADER_STATE_RECEIVE :
                   (w_take && w_last) ? MEMORY_LOADER_STATE_WRITE :
                   w_write ? ((w_halt || w_full) ? MEMORY_LOADER_STATE_DONE : MEMORY_LOADER_STATE_RECEIVE) :
                   r_state;
  end
  // The address saturates at the last word so a full memory never wraps back to 0.
  always_comb begin
    w_cnt = w_start ? '0 : w_take ? (w_last ? '0 : r_cnt + 1'b1) : r_cnt;
    w_shift = w_take ? {r_shift[WORD_SIZE-UART_BUS_SIZE-1:0], bus.i_rx_data} : r_shift;
    w_addr = w_start ? '0 : (w_write && !w_full) ? r_addr + 1'b1 : r_addr;
    w_words = w_start ? '0 : w_write ? r_words + 1'b1 : r_words;
    w_err = w_start ? 1'b0 : (w_write && !w_halt && w_full) ? 1'b1 : r_err;
    w_wr_data = w_write ? r_shift : r_wr_data;
  end
  assign bus.o_wr_en = r_wr_en;
  assign bus.o_wr_addr = r_wr_addr;
  assign bus.o_wr_data = r_wr_data;
  assign bus.o_busy = r_busy;
  assign bus.o_end = r_end;
  assign bus.o_error = r_error;
  assign bus.o_word_count = r_word_count;
endmodule

// File: doc/memory_loader.md
# memory_loader

Host-to-target program loader in the debugger path: consumes the byte stream delivered by the UART receiver, packs bytes into memory words, and writes them sequentially into instruction memory. It is the inbound counterpart of the debugger's memory dump printer. The debugger FSM starts it with a one-cycle `i_start` and waits for `o_end`.

## Interface
- `UART_BUS_SIZE`, 8: width of one received UART byte.
- `WORD_SIZE`, 32: memory word width; must be a multiple of `UART_BUS_SIZE`.
- `ADDR_SIZE`, 8: memory word-address width; capacity is 2^`ADDR_SIZE` words.
- `HALT_WORD`, 32'hFFFF_FFFF: terminating word; it is written, then the load ends.

Ports:
- `i_clk` input 1: clock, rising-edge.
- `i_reset` input 1: asynchronous, active-low reset.
- `i_start` input 1: one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- `i_rx_done` input 1: one-cycle strobe, `i_rx_data` valid.
- `i_rx_data` input `UART_BUS_SIZE`: received byte.
- `o_wr_en` output 1: one-cycle memory write strobe.
- `o_wr_addr` output `ADDR_SIZE`: word address for `o_wr_en`.
- `o_wr_data` output `WORD_SIZE`: word for `o_wr_en`.
- `o_busy` output 1: high in RECEIVE and WRITE.
- `o_end` output 1: level; high from load completion until the next accepted `i_start`.
- `o_error` output 1: level; overflow flag, same lifetime as `o_end`.
- `o_word_count` output `ADDR_SIZE`+1: number of words written in the current or last load.

## Operation
- Bytes per word: `BYTES = WORD_SIZE / UART_BUS_SIZE`. The first byte received is the most-significant byte (big-endian).
- States:
  - IDLE: the state after reset.
  - RECEIVE: shift in bytes.
  - WRITE: one cycle; issues the write.
  - DONE: holds `o_end`.
- IDLE/DONE, `i_start`=1:
  - Clear the byte counter, address, `o_word_count`, `o_end` and `o_error`.
  - Go to RECEIVE.
- RECEIVE, `i_rx_done`=1:
  - `shift = {shift[WORD_SIZE-UART_BUS_SIZE-1:0], i_rx_data}`.
  - Byte counter +1.
  - On the `BYTES`th byte: counter clears and the state goes to WRITE.
- WRITE:
  - Drive `o_wr_en`=1 with `o_wr_addr`=address and `o_wr_data`=shift.
  - `o_word_count` +1 and address +1.
  - If shift == `HALT_WORD`: go to DONE with `o_end`=1.
  - Else if the written address was 2^`ADDR_SIZE`−1 (memory now full): go to DONE with `o_end`=1 and `o_error`=1.
  - Else: back to RECEIVE.
- Address never wraps. A load that fills memory without a halt word is flagged as an error. The halt word at the last address is a normal end, not an error.
- `i_rx_done` while in IDLE, DONE or WRITE: byte dropped. The UART guarantees ≥10 bit-times between bytes, so no byte is lost in WRITE.
- `i_start` in RECEIVE/WRITE: ignored.
- Partial word at any time: nothing is written; there is no timeout (the host re-issues reset).

## Timing
- Reset (async assert, sync release):
  - State IDLE.
  - `o_wr_en`, `o_busy`, `o_end`, `o_error` = 0.
  - `o_wr_addr`, `o_wr_data`, `o_word_count` = 0.
- All outputs are registered.
- `i_start` at edge N: `o_busy`=1 and `o_end`=0 from N+1.
- Last byte's `i_rx_done` at edge N: `o_wr_en`=1 during cycle N+1 (registered, visible after edge N+1 until N+2). `o_wr_addr`/`o_wr_data` are stable in that cycle.
- `o_end`, `o_busy`=0 and the updated `o_word_count` are visible the cycle after the write strobe.
- `o_wr_data` holds its last value after the write; `o_wr_addr` shows the next address.
- Reset asserted mid-load: outputs clear immediately. Words already written stay in memory, and no `o_end` is produced.

## Structure
- Shared debugger header:
  - State encodings `MEMORY_LOADER_STATE_IDLE/RECEIVE/WRITE/DONE` (2 bits).
  - `DEFAULT_MEMORY_LOADER_*` parameter defaults.
  - The `HALT_WORD` constant, shared with the CPU decoder.
  - The existing `CLEAR`/`HIGH`/`LOW` macros.
- Single module with no sub-modules.
- Two-process style: a registered state block and a combinational next-state block.
- Byte counter width: `$clog2(BYTES)`.

## Test plan
- Three words 32'h0000_0001, 32'h1234_5678, `HALT_WORD`, sent as 12 bytes MSB-first → writes at addr 0, 1, 2 with exact data. `o_end`=1, `o_error`=0, `o_word_count`=3.
- `ADDR_SIZE`=2, four non-halt words → 4 writes at addr 0–3, then `o_end`=1, `o_error`=1, `o_word_count`=4, and a fifth word is ignored.
- Async reset pulse after 6 bytes → all outputs 0 immediately. A following `i_start` plus a halt word writes addr 0 only.
- `i_start` pulsed mid-word and `i_rx_done` strobed in IDLE → both ignored; the byte order of the current word is unchanged.
- Back-to-back loads: a second `i_start` while `o_end`=1 → `o_end` drops next cycle, the address restarts at 0, and the count resets.
- `i_rx_done` asserted on consecutive cycles at 10-cycle spacing → one `o_wr_en` pulse per 4 bytes, exactly one cycle wide, and no dropped bytes.
